mem_dump: RTL and testbench



---
 rtl/mem_dump_if.sv | 24 ++
 rtl/mem_dump.sv | 79 +++++++
 tb/tb_mem_dump.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_dump_if.sv
// mem_dump_if: memory-controller initiator and serial-TX signals used by mem_dump.
interface mem_dump_if #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic                  mem_r_en;
  logic                  mem_w_en;
  logic                  mem_rdy;
  logic                  mem_cplt;
  logic [7:0]            serial_data_out;
  logic                  serial_out_en;
  logic                  serial_out_rdy;
  modport master (
    output mem_addr, mem_data_in, mem_r_en, mem_w_en, serial_data_out, serial_out_en,
    input  mem_rdy, mem_cplt, mem_data_out, serial_out_rdy
  );
  modport slave (
    input  mem_addr, mem_data_in, mem_r_en, mem_w_en, serial_data_out, serial_out_en,
    output mem_rdy, mem_cplt, mem_data_out, serial_out_rdy
  );
endinterface

// File: rtl/mem_dump.sv
// mem_dump: reads a run of 16-bit memory words and sends each over serial TX, high byte first.
module mem_dump #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  word_count,
  output logic                  busy,
  output logic                  done,
  mem_dump_if.master            bus
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] MEM_REQ  = 3'd1;
  localparam logic [2:0] MEM_WAIT = 3'd2;
  localparam logic [2:0] TX_HI    = 3'd3;
  localparam logic [2:0] GAP_HI   = 3'd4;
  localparam logic [2:0] TX_LO    = 3'd5;
  localparam logic [2:0] GAP_LO   = 3'd6;
  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [DATA_WIDTH-1:0] word;
  logic [7:0]            sdo;
  logic                  last;
  assign busy                = state != IDLE;
  assign last                = remaining == LEN_WIDTH'(1);
  assign bus.mem_addr        = addr;
  assign bus.mem_data_in     = '0;
  assign bus.mem_w_en        = 1'b0;
  assign bus.mem_r_en        = state == MEM_REQ && bus.mem_rdy;
  assign bus.serial_out_en   = (state == TX_HI || state == TX_LO) && bus.serial_out_rdy;
  assign bus.serial_data_out = sdo;
  // sdo is loaded on entry to each TX state so it holds its value everywhere else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      word      <= '0;
      sdo       <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (word_count == '0) done <= 1'b1;
          else begin
            addr      <= start_addr;
            remaining <= word_count;
            state     <= MEM_REQ;
          end
        end
        MEM_REQ: if (bus.mem_rdy) state <= MEM_WAIT;
        MEM_WAIT: if (bus.mem_cplt) begin
          word  <= bus.mem_data_out;
          sdo   <= bus.mem_data_out[15:8];
          state <= TX_HI;
        end
        TX_HI: if (bus.serial_out_rdy) state <= GAP_HI;
        GAP_HI: begin
          sdo   <= word[7:0];
          state <= TX_LO;
        end
        TX_LO: if (bus.serial_out_rdy) state <= GAP_LO;
        GAP_LO: begin
          addr      <= addr + ADDR_WIDTH'(1);
          remaining <= remaining - LEN_WIDTH'(1);
          done      <= last;
          state     <= last ? IDLE : MEM_REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_dump.sv
// tb_mem_dump: directed bench for mem_dump with a 2-cycle memory model and serial byte capture.
module tb_mem_dump;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] start_addr;
  logic [23:0] word_count;
  logic        busy, done;
  logic        inj;
  int          tests = 0, fails = 0;
  int          reads = 0, strobes = 0, overlap = 0, viol = 0, cnt = 0;
  logic [23:0] la;
  logic [15:0] mem [logic [23:0]];
  logic [7:0]  bytes [$];
  logic [23:0] raddr [$];
  mem_dump_if #(.ADDR_WIDTH(24), .DATA_WIDTH(16)) bus ();
  mem_dump #(.ADDR_WIDTH(24), .DATA_WIDTH(16), .LEN_WIDTH(24)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .word_count(word_count), .busy(busy), .done(done), .bus(bus)
  );
  always #10 clk = ~clk;
  // memory answers every read two cycles after the request
  always @(posedge clk) begin
    bus.mem_cplt     <= cnt == 1 || inj;
    bus.mem_data_out <= cnt == 1 ? (mem.exists(la) ? mem[la] : 16'hDEAD) : 16'h0BAD;
    if (cnt != 0) cnt <= cnt - 1;
    if (bus.mem_r_en) begin
      cnt   <= 2;
      la    <= bus.mem_addr;
      reads <= reads + 1;
      raddr.push_back(bus.mem_addr);
    end
    if (bus.serial_out_en) begin
      strobes <= strobes + 1;
      bytes.push_back(bus.serial_data_out);
    end
  end
  always @(negedge clk) begin
    if (busy && done) overlap <= overlap + 1;
    if ((bus.mem_r_en && !bus.mem_rdy) || (bus.serial_out_en && !bus.serial_out_rdy)) viol <= viol + 1;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic kick(input logic [23:0] a, input logic [23:0] n);
    start = 1'b1; start_addr = a; word_count = n;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    chk({tag, "_done_seen"}, 64'(done), 64'(1));
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, {done, busy}, 2'b00);
  endtask
  initial begin
    int b0, r0, s0, bad;
    mem[24'h000010] = 16'hA55A;
    mem[24'h000100] = 16'h1234;
    mem[24'h000101] = 16'h5678;
    mem[24'h000102] = 16'h9ABC;
    mem[24'hFFFFFF] = 16'hC0DE;
    mem[24'h000000] = 16'hBEEF;
    mem[24'h000055] = 16'h5555;
    rst_n = 1'b0; start = 1'b0; start_addr = '0; word_count = '0; inj = 1'b0;
    bus.mem_rdy = 1'b1; bus.serial_out_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {busy, done, bus.mem_r_en, bus.mem_w_en, bus.serial_out_en}, 5'b0);
    chk("reset_data", {bus.mem_addr, bus.mem_data_in, bus.serial_data_out}, 48'h0);
    rst_n = 1'b1;
    @(negedge clk);
    // single word
    b0 = bytes.size(); r0 = reads; s0 = strobes;
    kick(24'h000010, 24'd1);
    chk("single_first_read", {bus.mem_r_en, bus.mem_addr, busy}, {1'b1, 24'h000010, 1'b1});
    wait_done("single");
    chk("single_counts", {32'(reads - r0), 32'(strobes - s0)}, {32'd1, 32'd2});
    chk("single_bytes", {bytes[b0], bytes[b0+1]}, 16'hA55A);
    // multi word
    b0 = bytes.size(); r0 = reads; s0 = strobes;
    kick(24'h000100, 24'd3);
    wait_done("multi");
    chk("multi_counts", {32'(reads - r0), 32'(strobes - s0)}, {32'd3, 32'd6});
    chk("multi_bytes", {bytes[b0], bytes[b0+1], bytes[b0+2], bytes[b0+3], bytes[b0+4], bytes[b0+5]}, 48'h123456789ABC);
    // zero count
    r0 = reads; s0 = strobes;
    kick(24'h000010, 24'd0);
    chk("zero_done", {done, busy}, 2'b10);
    @(negedge clk);
    chk("zero_after", {done, busy}, 2'b00);
    repeat (5) @(negedge clk);
    chk("zero_no_traffic", {32'(reads - r0), 32'(strobes - s0)}, 64'h0);
    // wrap and start ignored while busy
    b0 = bytes.size(); r0 = raddr.size();
    kick(24'hFFFFFF, 24'd2);
    repeat (3) @(negedge clk);
    kick(24'h000055, 24'd5);
    wait_done("wrap");
    chk("wrap_reads", {32'(raddr.size() - r0), 8'h0, raddr[r0], 8'h0, raddr[r0+1]}, {32'd2, 32'h00FFFFFF, 32'h00000000});
    chk("wrap_bytes", {bytes[b0], bytes[b0+1], bytes[b0+2], bytes[b0+3]}, 32'hC0DEBEEF);
    chk("wrap_addr_after", 64'(bus.mem_addr), 64'h1);
    // serial backpressure in TX_HI
    b0 = bytes.size(); s0 = strobes; bad = 0;
    bus.serial_out_rdy = 1'b0;
    kick(24'h000010, 24'd1);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 500; i++) begin
      if (bus.serial_out_en !== 1'b0 || bus.serial_data_out !== 8'hA5) bad++;
      @(negedge clk);
    end
    chk("bp_serial_hold", {32'(bad), 32'(strobes - s0)}, 64'h0);
    bus.serial_out_rdy = 1'b1;
    #1;
    chk("bp_serial_strobe", {bus.serial_out_en, bus.serial_data_out}, {1'b1, 8'hA5});
    wait_done("bp_serial");
    chk("bp_serial_bytes", {bytes[b0], bytes[b0+1]}, 16'hA55A);
    // memory backpressure
    b0 = bytes.size(); r0 = reads; bad = 0;
    bus.mem_rdy = 1'b0;
    kick(24'h000100, 24'd1);
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_r_en !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("bp_mem_hold", {32'(bad), 32'(reads - r0), 31'h0, busy}, {64'h0, 32'h1});
    bus.mem_rdy = 1'b1;
    #1;
    chk("bp_mem_req", {bus.mem_r_en, bus.mem_addr}, {1'b1, 24'h000100});
    wait_done("bp_mem");
    chk("bp_mem_bytes", {bytes[b0], bytes[b0+1]}, 16'h1234);
    // reset while waiting on memory
    s0 = strobes;
    kick(24'h000010, 24'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_outputs", {busy, done, bus.mem_r_en, bus.serial_out_en, bus.mem_addr, bus.serial_data_out}, 36'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_cplt_dropped", {32'(strobes - s0), 31'h0, busy}, 64'h0);
    b0 = bytes.size();
    kick(24'h000100, 24'd2);
    wait_done("rst_fresh");
    chk("rst_fresh_bytes", {bytes[b0], bytes[b0+1], bytes[b0+2], bytes[b0+3]}, 32'h12345678);
    chk("monitors", {32'(overlap), 32'(viol)}, 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
